// File: rtl/nf_10g_link_sequencer.sv
// nf_10g_link_sequencer: bring-up / recovery sequencer for one 10G SFP+ port.
// Walks the transceiver through reset, QPLL lock, GT reset-done and block lock,
// then enables the datapath. Link loss or faults trigger a bounded retry loop.
// Optional statistics outputs are built when NF_10G_SEQ_STATS_EN is defined.
module nf_10g_link_sequencer #(
   parameter int unsigned C_RESET_PULSE_CYCLES = 16,
   parameter int unsigned C_TIMEOUT_CYCLES     = 1000000,
   parameter int unsigned C_DEBOUNCE_CYCLES    = 1024,
   parameter int unsigned C_BACKOFF_CYCLES     = 4096,
   parameter int unsigned C_MAX_RETRIES        = 7
) (
   input  logic       core_clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       tx_abs,
   input  logic       tx_fault,
   input  logic       qplllock,
   input  logic       resetdone,
   input  logic [7:0] pcspma_status,
   output logic       xcvr_reset,
   output logic       tx_disable_force,
   output logic       datapath_en,
   output logic       link_up,
   output logic [2:0] seq_state,
   output logic       retry_exhausted
`ifdef NF_10G_SEQ_STATS_EN
   ,
   output logic [15:0] link_flap_count,
   output logic [15:0] retry_total
`endif
);

   localparam int unsigned CW = 32;
   localparam int unsigned RW = 8;
   localparam logic [CW-1:0] PULSE_LIM   = CW'(C_RESET_PULSE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LIM = CW'(C_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] DEB_LIM     = CW'(C_DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] BACKOFF_LIM = CW'(C_BACKOFF_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX   = RW'(C_MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RESET     = 3'd1,
      S_WAIT_PLL  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_WAIT_LOCK = 3'd4,
      S_LINK_UP   = 3'd5,
      S_BACKOFF   = 3'd6,
      S_FAULT     = 3'd7
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [1:0]    qpll_sync;
   logic [1:0]    done_sync;
   logic          qplllock_s;
   logic          resetdone_s;
   logic          block_lock;
   logic          state_change;
   logic [CW-1:0] cnt;
   logic [CW-1:0] deb;
   logic [RW-1:0] retry;
   logic          xcvr_reset_d;
   logic          tx_disable_force_d;
   logic          datapath_en_d;
   logic          link_up_d;
   logic          retry_exhausted_d;
   logic          unused_status;

   assign qplllock_s    = qpll_sync[1];
   assign resetdone_s   = done_sync[1];
   assign block_lock    = pcspma_status[0];
   assign unused_status = ^pcspma_status[7:1];
   assign state_change  = (state_next != state);

   // Two-flop synchronisers for the asynchronous transceiver status inputs
   always_ff @(posedge core_clk) begin
      if (reset) begin
         qpll_sync <= '0;
         done_sync <= '0;
      end else begin
         qpll_sync <= {qpll_sync[0], qplllock};
         done_sync <= {done_sync[0], resetdone};
      end
   end

   // State register
   always_ff @(posedge core_clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state: global enable/absent/fault priority, then per-state progress
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (enable && !tx_abs && !tx_fault) state_next = S_RESET;
         end
         S_FAULT: begin
            if (!enable) state_next = S_IDLE;
         end
         default: begin
            if (!enable || tx_abs) begin
               state_next = S_IDLE;
            end else if (tx_fault) begin
               state_next = S_BACKOFF;
            end else begin
               case (state)
                  S_RESET: begin
                     if (cnt >= PULSE_LIM) state_next = S_WAIT_PLL;
                  end
                  S_WAIT_PLL: begin
                     if (qplllock_s)              state_next = S_WAIT_DONE;
                     else if (cnt >= TIMEOUT_LIM) state_next = S_BACKOFF;
                  end
                  S_WAIT_DONE: begin
                     if (resetdone_s)             state_next = S_WAIT_LOCK;
                     else if (cnt >= TIMEOUT_LIM) state_next = S_BACKOFF;
                  end
                  S_WAIT_LOCK: begin
                     if (block_lock && deb >= DEB_LIM) state_next = S_LINK_UP;
                     else if (cnt >= TIMEOUT_LIM)      state_next = S_BACKOFF;
                  end
                  S_LINK_UP: begin
                     if (!block_lock || !qplllock_s) state_next = S_BACKOFF;
                  end
                  S_BACKOFF: begin
                     if (retry == RETRY_MAX)      state_next = S_FAULT;
                     else if (cnt >= BACKOFF_LIM) state_next = S_RESET;
                  end
                  default: state_next = S_IDLE;
               endcase
            end
         end
      endcase
   end

   // Per-state cycle counter, lock debounce counter and retry count
   always_ff @(posedge core_clk) begin
      if (reset) begin
         cnt   <= '0;
         deb   <= '0;
         retry <= '0;
      end else begin
         if (state_change)   cnt <= '0;
         else if (cnt != '1) cnt <= cnt + CW'(1);

         if (state == S_WAIT_LOCK && !state_change && block_lock) begin
            if (deb != '1) deb <= deb + CW'(1);
         end else begin
            deb <= '0;
         end

         if (state == S_IDLE) begin
            retry <= '0;
         end else if (state_change && state_next == S_BACKOFF) begin
            if (retry != '1) retry <= retry + RW'(1);
         end else if (state_change && state_next == S_LINK_UP) begin
            retry <= '0;
         end
      end
   end

   // Output decode from the current state
   always_comb begin
      xcvr_reset_d       = 1'b1;
      tx_disable_force_d = 1'b1;
      datapath_en_d      = 1'b0;
      link_up_d          = 1'b0;
      retry_exhausted_d  = 1'b0;
      case (state)
         S_WAIT_PLL, S_WAIT_DONE: begin
            xcvr_reset_d = 1'b0;
         end
         S_WAIT_LOCK: begin
            xcvr_reset_d       = 1'b0;
            tx_disable_force_d = 1'b0;
         end
         S_LINK_UP: begin
            xcvr_reset_d       = 1'b0;
            tx_disable_force_d = 1'b0;
            datapath_en_d      = 1'b1;
            link_up_d          = 1'b1;
         end
         S_FAULT: begin
            retry_exhausted_d = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output registers
   always_ff @(posedge core_clk) begin
      if (reset) begin
         xcvr_reset       <= 1'b1;
         tx_disable_force <= 1'b1;
         datapath_en      <= 1'b0;
         link_up          <= 1'b0;
         seq_state        <= 3'd0;
         retry_exhausted  <= 1'b0;
      end else begin
         xcvr_reset       <= xcvr_reset_d;
         tx_disable_force <= tx_disable_force_d;
         datapath_en      <= datapath_en_d;
         link_up          <= link_up_d;
         seq_state        <= state;
         retry_exhausted  <= retry_exhausted_d;
      end
   end

`ifdef NF_10G_SEQ_STATS_EN
   // Saturating flap and retry statistics; only reset clears them
   always_ff @(posedge core_clk) begin
      if (reset) begin
         link_flap_count <= '0;
         retry_total     <= '0;
      end else if (state_change && state_next == S_BACKOFF) begin
         if (retry_total != 16'hFFFF) retry_total <= retry_total + 16'd1;
         if (state == S_LINK_UP && link_flap_count != 16'hFFFF)
            link_flap_count <= link_flap_count + 16'd1;
      end
   end
`endif

endmodule
